// File: rtl/tdm_burst_mac_if.sv
// Bundles the sample, coefficient and result signals of tdm_burst_mac.
// slave is the MAC side; master is the producer/consumer side.
interface tdm_burst_mac_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned ACC_WIDTH = 24
);
  localparam int unsigned ChanW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 coef_we;
  logic [ChanW-1:0]     coef_addr;
  logic [WIDTH-1:0]     coef_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ChanW-1:0]     out_chan;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_sat;
  logic                 busy;
  logic                 drop_err;

  modport slave (
    input  in_valid, in_data, in_last, coef_we, coef_addr, coef_data, out_ready,
    output out_valid, out_chan, out_data, out_sat, busy, drop_err
  );

  modport master (
    output in_valid, in_data, in_last, coef_we, coef_addr, coef_data, out_ready,
    input  out_valid, out_chan, out_data, out_sat, busy, drop_err
  );
endinterface

// File: rtl/tdm_burst_mac.sv
// Per-channel TDM multiply-accumulate over one FIFO read burst, drained as CHANNELS results.
// Define TDM_ACC_SATURATE_EN for clamping accumulators with sticky sat flags; default wraps.
module tdm_burst_mac #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned BURST_LEN = 100,
  parameter int unsigned ACC_WIDTH = 24
) (
  input logic            rd_clk,
  input logic            rst,
  tdm_burst_mac_if.slave bus
);
  localparam int unsigned ChanW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CntW  = $clog2(BURST_LEN + 1);
  localparam int unsigned ProdW = 2 * WIDTH;
  localparam logic [ChanW-1:0] LastChan = ChanW'(CHANNELS - 1);
  localparam logic [CntW-1:0]  BurstMax = CntW'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StAccum, StFlush, StDrain} state_e;

  state_e           state_q, state_d;
  logic             flush_q, flush_d;
  logic [ChanW-1:0] chan_q, chan_d, cur_chan;
  logic [ChanW-1:0] out_chan_q, out_chan_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic             accept, drop, clear_acc, drop_err_q, out_valid;

  logic [WIDTH-1:0]     coef_q [CHANNELS];
  logic [ACC_WIDTH-1:0] acc_q  [CHANNELS];

  logic             s_valid_q;
  logic [WIDTH-1:0] s_data_q, s_coef_q;
  logic [ChanW-1:0] s_chan_q;
  logic             p_valid_q;
  logic [ChanW-1:0] p_chan_q;
  logic [ProdW-1:0] prod_q;

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    out_chan_d = out_chan_q;
    cur_chan   = chan_q;
    accept     = 1'b0;
    drop       = 1'b0;
    clear_acc  = 1'b0;
    cnt_inc    = ((state_q == StIdle) ? '0 : cnt_q) + CntW'(1);

    unique case (state_q)
      StIdle: begin
        cur_chan = '0;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (bus.in_valid) accept = 1'b1;
      end
      StFlush: begin
        drop = bus.in_valid;
        if (flush_q) begin
          flush_d    = 1'b0;
          out_chan_d = '0;
          state_d    = StDrain;
        end else begin
          flush_d = 1'b1;
        end
      end
      StDrain: begin
        drop = bus.in_valid;
        if (bus.out_ready) begin
          if (out_chan_q == LastChan) begin
            out_chan_d = '0;
            clear_acc  = 1'b1;
            state_d    = StIdle;
          end else begin
            out_chan_d = out_chan_q + ChanW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Burst ends on in_last or on the sample that fills BURST_LEN, whichever is first.
    if (accept) begin
      if (bus.in_last || (cnt_inc == BurstMax)) begin
        state_d = StFlush;
        chan_d  = '0;
        cnt_d   = '0;
      end else begin
        chan_d = (cur_chan == LastChan) ? '0 : cur_chan + ChanW'(1);
        cnt_d  = cnt_inc;
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      flush_q    <= 1'b0;
      chan_q     <= '0;
      cnt_q      <= '0;
      out_chan_q <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      out_chan_q <= out_chan_d;
      drop_err_q <= drop;
    end
  end

  // Nonblocking write means a same-cycle sample still captures the old coefficient.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CHANNELS); i++) coef_q[i] <= WIDTH'(1);
    end else if (bus.coef_we) begin
      coef_q[bus.coef_addr] <= bus.coef_data;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_coef_q  <= '0;
      s_chan_q  <= '0;
      p_valid_q <= 1'b0;
      p_chan_q  <= '0;
      prod_q    <= '0;
    end else begin
      s_valid_q <= accept;
      if (accept) begin
        s_data_q <= bus.in_data;
        s_chan_q <= cur_chan;
        s_coef_q <= coef_q[cur_chan];
      end
      p_valid_q <= s_valid_q;
      if (s_valid_q) begin
        p_chan_q <= s_chan_q;
        prod_q   <= ProdW'(s_data_q) * ProdW'(s_coef_q);
      end
    end
  end

`ifdef TDM_ACC_SATURATE_EN
  localparam int unsigned SumW = ACC_WIDTH + 1;

  logic            sat_q [CHANNELS];
  logic [SumW-1:0] sum;

  assign sum = SumW'(acc_q[p_chan_q]) + SumW'(prod_q);

  always_ff @(posedge rd_clk) begin
    if (rst || clear_acc) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        acc_q[i] <= '0;
        sat_q[i] <= 1'b0;
      end
    end else if (p_valid_q) begin
      if (sum[ACC_WIDTH]) begin
        acc_q[p_chan_q] <= '1;
        sat_q[p_chan_q] <= 1'b1;
      end else begin
        acc_q[p_chan_q] <= sum[ACC_WIDTH-1:0];
      end
    end
  end

  assign bus.out_sat = out_valid & sat_q[out_chan_q];
`else
  always_ff @(posedge rd_clk) begin
    if (rst || clear_acc) begin
      for (int i = 0; i < int'(CHANNELS); i++) acc_q[i] <= '0;
    end else if (p_valid_q) begin
      acc_q[p_chan_q] <= acc_q[p_chan_q] + ACC_WIDTH'(prod_q);
    end
  end

  assign bus.out_sat = 1'b0;
`endif

  assign out_valid     = (state_q == StDrain);
  assign bus.out_valid = out_valid;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_data  = out_valid ? acc_q[out_chan_q] : '0;
  assign bus.busy      = (state_q != StIdle);
  assign bus.drop_err  = drop_err_q;
endmodule

// File: tb/tb_tdm_burst_mac.sv
// Directed bench for tdm_burst_mac: default instance plus an ACC_WIDTH=16 instance for overflow.
module tb_tdm_burst_mac;
  logic rd_clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   hs_cnt   = 0;

  tdm_burst_mac_if #(.WIDTH(8), .CHANNELS(4), .ACC_WIDTH(24)) bus ();
  tdm_burst_mac_if #(.WIDTH(8), .CHANNELS(4), .ACC_WIDTH(16)) bus16 ();

  tdm_burst_mac #(.WIDTH(8), .CHANNELS(4), .BURST_LEN(100), .ACC_WIDTH(24)) dut (
    .rd_clk (rd_clk),
    .rst    (rst),
    .bus    (bus)
  );

  tdm_burst_mac #(.WIDTH(8), .CHANNELS(4), .BURST_LEN(100), .ACC_WIDTH(16)) dut16 (
    .rd_clk (rd_clk),
    .rst    (rst),
    .bus    (bus16)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) if (bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [7:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic set_coef(input int ch, input logic [7:0] v);
    bus.coef_we   = 1'b1;
    bus.coef_addr = ch[1:0];
    bus.coef_data = v;
    tick();
    bus.coef_we = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drain(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e[4];
    int          base;
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    e[3] = e3;
    wait_valid({tag, "_valid"});
    base          = hs_cnt;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s_chan%0d", tag, c), 32'(bus.out_chan), 32'(c));
      chk($sformatf("%s_data%0d", tag, c), 32'(bus.out_data), e[c]);
      chk($sformatf("%s_sat%0d", tag, c), 32'(bus.out_sat), 32'd0);
      tick();
    end
    bus.out_ready = 1'b0;
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hs_count"}, 32'(hs_cnt - base), 32'd4);
  endtask

  initial begin
    int          base;
    int          n;
    logic [31:0] e[4];
    logic [31:0] exp16;
    logic        exp16_sat;

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_last     = 1'b0;
    bus.coef_we     = 1'b0;
    bus.coef_addr   = '0;
    bus.coef_data   = '0;
    bus.out_ready   = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.in_data   = '0;
    bus16.in_last   = 1'b0;
    bus16.coef_we   = 1'b0;
    bus16.coef_addr = '0;
    bus16.coef_data = '0;
    bus16.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_chan", 32'(bus.out_chan), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_sat", 32'(bus.out_sat), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_drop_err", 32'(bus.drop_err), 32'd0);

    // Coefficients {1,2,3,4}, burst 1..8 with in_last on 8
    for (int i = 0; i < 4; i++) set_coef(i, 8'(i + 1));
    for (int k = 1; k <= 8; k++) sample(8'(k), k == 8);
    chk("lat_t1_valid", 32'(bus.out_valid), 32'd0);
    chk("lat_t1_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("lat_t2_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_t3_valid", 32'(bus.out_valid), 32'd1);
    drain("b8", 32'd6, 32'd16, 32'd30, 32'd48);

    // 100 samples of 255, no in_last, coefficients 255
    for (int i = 0; i < 4; i++) set_coef(i, 8'd255);
    for (int k = 1; k <= 100; k++) sample(8'd255, 1'b0);
    chk("b100_flush_busy", 32'(bus.busy), 32'd1);
    drain("b100", 32'd1625625, 32'd1625625, 32'd1625625, 32'd1625625);

    // DRAIN stall with out_ready low 5 cycles, then pulsed
    for (int k = 1; k <= 4; k++) sample(8'(k), k == 4);
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_chan_c%0d", i), 32'(bus.out_chan), 32'd0);
      chk($sformatf("stall_data_c%0d", i), 32'(bus.out_data), 32'd255);
      tick();
    end
    e[0] = 32'd255;
    e[1] = 32'd510;
    e[2] = 32'd765;
    e[3] = 32'd1020;
    base = hs_cnt;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("pulse_chan%0d", c), 32'(bus.out_chan), 32'(c));
      chk($sformatf("pulse_data%0d", c), 32'(bus.out_data), e[c]);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      tick();
    end
    chk("pulse_hs_count", 32'(hs_cnt - base), 32'd4);
    chk("pulse_busy_end", 32'(bus.busy), 32'd0);
    chk("pulse_valid_end", 32'(bus.out_valid), 32'd0);

    // Samples during FLUSH and DRAIN are dropped
    for (int k = 1; k <= 4; k++) sample(8'(k), k == 4);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    tick();
    bus.in_valid = 1'b0;
    chk("drop_flush_pulse", 32'(bus.drop_err), 32'd1);
    tick();
    chk("drop_flush_clear", 32'(bus.drop_err), 32'd0);
    chk("drop_in_drain", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd77;
    tick();
    bus.in_valid = 1'b0;
    chk("drop_drain_pulse", 32'(bus.drop_err), 32'd1);
    tick();
    chk("drop_drain_clear", 32'(bus.drop_err), 32'd0);
    drain("drop", 32'd255, 32'd510, 32'd765, 32'd1020);

    // Reset in ACCUM after 3 samples, then a fresh burst 1..4
    sample(8'd50, 1'b0);
    sample(8'd60, 1'b0);
    sample(8'd70, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 1; k <= 4; k++) sample(8'(k), k == 4);
    drain("midrst", 32'd1, 32'd2, 32'd3, 32'd4);

    // Coefficient write to ch1 in the same cycle a ch1 sample is accepted
    sample(8'd10, 1'b0);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'd1;
    bus.coef_data = 8'd7;
    sample(8'd20, 1'b0);
    bus.coef_we = 1'b0;
    sample(8'd30, 1'b0);
    sample(8'd40, 1'b1);
    drain("coef_old", 32'd10, 32'd20, 32'd30, 32'd40);
    // Short burst: new ch1 coefficient applies, untouched channels drain as 0
    sample(8'd5, 1'b0);
    sample(8'd6, 1'b1);
    drain("short", 32'd5, 32'd42, 32'd0, 32'd0);

    // ACC_WIDTH=16: two 255*255 products on ch0 overflow 16 bits
`ifdef TDM_ACC_SATURATE_EN
    exp16     = 32'd65535;
    exp16_sat = 1'b1;
`else
    exp16     = 32'd64514;
    exp16_sat = 1'b0;
`endif
    bus16.coef_we   = 1'b1;
    bus16.coef_addr = 2'd0;
    bus16.coef_data = 8'd255;
    tick();
    bus16.coef_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus16.in_valid = 1'b1;
      bus16.in_data  = (k == 0 || k == 4) ? 8'd255 : 8'd0;
      bus16.in_last  = (k == 4);
      tick();
    end
    bus16.in_valid = 1'b0;
    bus16.in_last  = 1'b0;
    n = 0;
    while (bus16.out_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("acc16_valid", 32'(bus16.out_valid), 32'd1);
    bus16.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("acc16_chan%0d", c), 32'(bus16.out_chan), 32'(c));
      chk($sformatf("acc16_data%0d", c), 32'(bus16.out_data), (c == 0) ? exp16 : 32'd0);
      chk($sformatf("acc16_sat%0d", c), 32'(bus16.out_sat),
          (c == 0) ? 32'(exp16_sat) : 32'd0);
      tick();
    end
    bus16.out_ready = 1'b0;
    chk("acc16_busy_end", 32'(bus16.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
